// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad emulator: FSM states, the
// key-code to (column,row) map of the 4x4 Pmod keypad, and matrix width.
package keypad_pkg;

    localparam int RC_W  = 4;   // rows and columns of the matrix
    localparam int KEY_W = 4;   // key code 0x0..0xF

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } state_t;

    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_pos_t;

    // Physical layout, columns left to right:
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
    localparam key_pos_t KEY_MAP [16] = '{
        '{col: 2'd0, row: 2'd3},   // 0
        '{col: 2'd0, row: 2'd0},   // 1
        '{col: 2'd1, row: 2'd0},   // 2
        '{col: 2'd2, row: 2'd0},   // 3
        '{col: 2'd0, row: 2'd1},   // 4
        '{col: 2'd1, row: 2'd1},   // 5
        '{col: 2'd2, row: 2'd1},   // 6
        '{col: 2'd0, row: 2'd2},   // 7
        '{col: 2'd1, row: 2'd2},   // 8
        '{col: 2'd2, row: 2'd2},   // 9
        '{col: 2'd3, row: 2'd0},   // A
        '{col: 2'd3, row: 2'd1},   // B
        '{col: 2'd3, row: 2'd2},   // C
        '{col: 2'd3, row: 2'd3},   // D
        '{col: 2'd2, row: 2'd3},   // E
        '{col: 2'd1, row: 2'd3}    // F
    };

endpackage

// File: rtl/keypad_emulator_if.sv
// Press-command channel: valid/ready handshake carrying key, hold and gap.
interface keypad_emulator_if #(
    parameter int HOLD_W = 24
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_key;
    logic [HOLD_W-1:0] req_hold;
    logic [HOLD_W-1:0] req_gap;

    modport master (
        output req_valid, req_key, req_hold, req_gap,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_key, req_hold, req_gap,
        output req_ready
    );
endinterface

// File: rtl/keypad_bounce_gen.sv
// Contact model for one press: closed on the first active cycle, then
// toggling every BOUNCE_STEP cycles while inside the bounce window, solid
// closed afterwards. Open whenever the press is not active.
module keypad_bounce_gen #(
    parameter logic [15:0] BOUNCE_CYCLES = 16'd2000,
    parameter logic [15:0] BOUNCE_STEP   = 16'd250
) (
    input  logic clk,
    input  logic clear,
    input  logic start,      // command accepted; press begins next cycle
    input  logic active,     // FSM is in PRESS
    output logic key_down
);

    logic [15:0] cyc_q, cyc_d;     // press cycle index, saturates at window end
    logic [15:0] step_q, step_d;   // position inside the current bounce step
    logic        open_q, open_d;   // contact currently bounced open
    logic        in_window;

    assign in_window = (cyc_q < BOUNCE_CYCLES);

    // Next-state for the bounce counters; restarted by every accepted command.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cyc_d  = cyc_q;
        step_d = step_q;
        open_d = open_q;
        if (start) begin
            cyc_d  = '0;
            step_d = '0;
            open_d = 1'b0;
        end else if (active) begin
            if (in_window) begin
                cyc_d = cyc_q + 16'd1;
            end
            if (step_q >= BOUNCE_STEP - 16'd1) begin
                step_d = '0;
                open_d = ~open_q;
            end else begin
                step_d = step_q + 16'd1;
            end
        end
    end

    // Bounce counter registers.
    always_ff @(posedge clk or negedge clear) begin
        // NOTE: flops use non-blocking assignments so all registers update together at the edge.
        if (!clear) begin
            cyc_q  <= '0;
            step_q <= '0;
            open_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            step_q <= step_d;
            open_q <= open_d;
        end
    end

    assign key_down = active && !(in_window && open_q);

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad stand-in: accepts press commands and answers the
// scanner's one-cold column strobes on the active-low row lines.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int          HOLD_W        = 24,
    parameter logic [15:0] BOUNCE_CYCLES = 16'd2000,
    parameter logic [15:0] BOUNCE_STEP   = 16'd250
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [RC_W-1:0]   col,
    output logic [RC_W-1:0]   row,
    keypad_emulator_if.slave  req,
    output logic              busy,
    output logic              key_down
);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] gap_q, gap_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              ready_q, ready_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic              accept;
    logic              press_active;
    key_pos_t          pos;

    // ready_q is low for the first cycle out of reset even though the FSM is IDLE.
    assign accept       = req.req_valid && ready_q && (state_q == IDLE);
    assign press_active = (state_q == PRESS);

    // Command FSM: latch on accept, count the hold down, then the gap.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        key_d   = key_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PRESS;
                    key_d   = req.req_key;
                    hold_d  = (req.req_hold == '0) ? HOLD_W'(1) : req.req_hold;
                    gap_d   = req.req_gap;
                end
            end
            PRESS: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q == HOLD_W'(1)) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                // A zero gap still spends one cycle here before IDLE.
                if (gap_q <= HOLD_W'(1)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // Row answer: pull the key's row low while its column is strobed.
    always_comb begin
        row_d = '1;
        pos   = KEY_MAP[key_q];
        if (key_down && !col[pos.col]) begin
            row_d[pos.row] = 1'b0;
        end
    end

    // State, counters, ready and row registers.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            hold_q  <= '0;
            gap_q   <= '0;
            key_q   <= '0;
            ready_q <= 1'b0;
            row_q   <= '1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            row_q   <= row_d;
        end
    end

    keypad_bounce_gen #(
        .BOUNCE_CYCLES (BOUNCE_CYCLES),
        .BOUNCE_STEP   (BOUNCE_STEP)
    ) u_bounce (
        .clk      (clk),
        .clear    (clear),
        .start    (accept),
        .active   (press_active),
        .key_down (key_down)
    );

    assign req.req_ready = ready_q;
    assign row           = row_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: dut0 has bounce disabled, dut1 uses an
// 8-cycle window with a 2-cycle step. Table vectors, hand sequences for
// gap/back-to-back/reset, and a randomized run against a timeline model.
module tb_keypad_emulator;

    localparam int BC   = 8;
    localparam int STEP = 2;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] col0, col1, row0, row1;
    logic       busy0, busy1, kd0, kd1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keypad_emulator_if #(.HOLD_W(24)) if0 ();
    keypad_emulator_if #(.HOLD_W(24)) if1 ();

    keypad_emulator #(.HOLD_W(24), .BOUNCE_CYCLES(16'd0), .BOUNCE_STEP(16'd1)) dut0 (
        .clk(clk), .clear(clear), .col(col0), .row(row0),
        .req(if0), .busy(busy0), .key_down(kd0)
    );

    keypad_emulator #(.HOLD_W(24), .BOUNCE_CYCLES(16'd8), .BOUNCE_STEP(16'd2)) dut1 (
        .clk(clk), .clear(clear), .col(col1), .row(row1),
        .req(if1), .busy(busy1), .key_down(kd1)
    );

    // Keypad layout as printed on the part, row by row, left to right.
    int layout [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

    typedef struct {
        logic [3:0]  key;
        logic [23:0] hold;
        logic [3:0]  col;
        logic [3:0]  exp_row;
        int          exp_len;
    } vec_t;

    vec_t tbl [8];
    bit   bpat [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void key_rc(input logic [3:0] k, output int c, output int r);
        c = 0;
        r = 0;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (layout[rr][cc] == int'(k)) begin
                    c = cc;
                    r = rr;
                end
    endfunction

    function automatic bit bounce_ref(input int i);
        if (i < BC) return ((i / STEP) % 2) == 0;
        return 1'b1;
    endfunction

    task automatic wait_ready0();
        int n = 0;
        while (!if0.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready0", 32'(if0.req_ready), 32'd1);
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (!if1.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready1", 32'(if1.req_ready), 32'd1);
    endtask

    initial begin
        int L;
        int ps, pl, gl, idle_from, cur_c, cur_r;
        logic [3:0] e_row, c_rnd, k_rnd;
        logic e_rdy, e_busy, e_kd, in_p, in_g, v;
        logic [23:0] h_rnd, g_rnd;

        tbl[0] = '{key: 4'h5, hold: 24'd10, col: 4'b1101, exp_row: 4'b1101, exp_len: 10};
        tbl[1] = '{key: 4'h5, hold: 24'd10, col: 4'b1110, exp_row: 4'b1111, exp_len: 10};
        tbl[2] = '{key: 4'hD, hold: 24'd0,  col: 4'b0111, exp_row: 4'b0111, exp_len: 1};
        tbl[3] = '{key: 4'h0, hold: 24'd3,  col: 4'b1110, exp_row: 4'b0111, exp_len: 3};
        tbl[4] = '{key: 4'hA, hold: 24'd2,  col: 4'b0111, exp_row: 4'b1110, exp_len: 2};
        tbl[5] = '{key: 4'h9, hold: 24'd4,  col: 4'b0000, exp_row: 4'b1011, exp_len: 4};
        tbl[6] = '{key: 4'h6, hold: 24'd1,  col: 4'b1111, exp_row: 4'b1111, exp_len: 1};
        tbl[7] = '{key: 4'hF, hold: 24'd5,  col: 4'b1101, exp_row: 4'b0111, exp_len: 5};
        bpat = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

        clear = 1'b0;
        col0 = 4'hF;
        col1 = 4'hF;
        if0.req_valid = 1'b0; if0.req_key = '0; if0.req_hold = '0; if0.req_gap = '0;
        if1.req_valid = 1'b0; if1.req_key = '0; if1.req_hold = '0; if1.req_gap = '0;

        // Reset state.
        #12;
        check("rst_row", 32'(row0), 32'hF);
        check("rst_ready", 32'(if0.req_ready), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_kd", 32'(kd0), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        #1;
        check("ready_before_edge", 32'(if0.req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_edge0", 32'(if0.req_ready), 32'd1);
        check("ready_after_edge1", 32'(if1.req_ready), 32'd1);

        // Table vectors on the bounce-free instance, gap 0.
        for (int i = 0; i < 8; i++) begin
            wait_ready0();
            if0.req_valid = 1'b1;
            if0.req_key   = tbl[i].key;
            if0.req_hold  = tbl[i].hold;
            if0.req_gap   = '0;
            col0          = tbl[i].col;
            L = tbl[i].exp_len;
            for (int k = 1; k <= L + 2; k++) begin
                @(negedge clk);
                if (k == 1) if0.req_valid = 1'b0;
                check($sformatf("tbl%0d_row_k%0d", i, k), 32'(row0),
                      (k >= 2 && k <= L + 1) ? 32'(tbl[i].exp_row) : 32'hF);
                check($sformatf("tbl%0d_kd_k%0d", i, k), 32'(kd0), (k <= L) ? 32'd1 : 32'd0);
                check($sformatf("tbl%0d_rdy_k%0d", i, k), 32'(if0.req_ready),
                      (k == L + 2) ? 32'd1 : 32'd0);
            end
        end

        // Gap of 5 followed by a held request for key A.
        wait_ready0();
        if0.req_valid = 1'b1;
        if0.req_key   = 4'h5;
        if0.req_hold  = 24'd3;
        if0.req_gap   = 24'd5;
        col0          = 4'b1101;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if0.req_key  = 4'hA;
                if0.req_hold = 24'd2;
                if0.req_gap  = 24'd0;
            end
            if (k <= 8) begin
                check($sformatf("gap_rdy_k%0d", k), 32'(if0.req_ready), 32'd0);
                check($sformatf("gap_busy_k%0d", k), 32'(busy0), 32'd1);
                check($sformatf("gap_kd_k%0d", k), 32'(kd0), (k <= 3) ? 32'd1 : 32'd0);
            end else if (k == 9) begin
                check("gap_rdy_k9", 32'(if0.req_ready), 32'd1);
                check("gap_busy_k9", 32'(busy0), 32'd0);
                col0 = 4'b0111;
            end else if (k == 10) begin
                check("gap_accept_busy", 32'(busy0), 32'd1);
                check("gap_accept_kd", 32'(kd0), 32'd1);
                check("gap_accept_rdy", 32'(if0.req_ready), 32'd0);
                if0.req_valid = 1'b0;
            end else begin
                check("gap_keyA_row", 32'(row0), 32'b1110);
            end
        end

        // Bounce pattern on key 1, column 0 strobed.
        wait_ready1();
        if1.req_valid = 1'b1;
        if1.req_key   = 4'h1;
        if1.req_hold  = 24'd20;
        if1.req_gap   = 24'd0;
        col1          = 4'b1110;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) if1.req_valid = 1'b0;
            check($sformatf("bnc_kd_k%0d", k), 32'(kd1), (k <= 20) ? 32'(bpat[k-1]) : 32'd0);
            check($sformatf("bnc_row_k%0d", k), 32'(row1),
                  (k >= 2 && k <= 21) ? {28'd0, 3'b111, ~bpat[k-2]} : 32'hF);
        end

        // Randomized commands and column strobes against the timeline model.
        wait_ready1();
        ps = -1000; pl = 0; gl = 0; idle_from = 0;
        cur_c = 0; cur_r = 0;
        e_row = 4'hF;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            in_p   = (t >= ps) && (t < ps + pl);
            in_g   = (t >= ps + pl) && (t < ps + pl + gl);
            e_rdy  = (t >= idle_from);
            e_busy = in_p || in_g;
            e_kd   = in_p && bounce_ref(t - ps);
            check($sformatf("rnd_rdy_t%0d", t), 32'(if1.req_ready), 32'(e_rdy));
            check($sformatf("rnd_busy_t%0d", t), 32'(busy1), 32'(e_busy));
            check($sformatf("rnd_kd_t%0d", t), 32'(kd1), 32'(e_kd));
            check($sformatf("rnd_row_t%0d", t), 32'(row1), 32'(e_row));
            v     = ($urandom_range(0, 2) != 0);
            k_rnd = 4'($urandom_range(0, 15));
            h_rnd = 24'($urandom_range(0, 12));
            g_rnd = 24'($urandom_range(0, 5));
            c_rnd = 4'($urandom_range(0, 15));
            if1.req_valid = v;
            if1.req_key   = k_rnd;
            if1.req_hold  = h_rnd;
            if1.req_gap   = g_rnd;
            col1          = c_rnd;
            e_row = 4'hF;
            if (e_kd && !c_rnd[cur_c]) e_row[cur_r] = 1'b0;
            if (v && e_rdy) begin
                ps = t + 1;
                pl = (h_rnd == 0) ? 1 : int'(h_rnd);
                gl = (g_rnd == 0) ? 1 : int'(g_rnd);
                idle_from = ps + pl + gl;
                key_rc(k_rnd, cur_c, cur_r);
            end
        end
        if1.req_valid = 1'b0;

        // Asynchronous reset in the middle of a press.
        wait_ready0();
        if0.req_valid = 1'b1;
        if0.req_key   = 4'h5;
        if0.req_hold  = 24'd40;
        if0.req_gap   = 24'd3;
        col0          = 4'b1101;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) if0.req_valid = 1'b0;
        end
        check("mid_row_pressed", 32'(row0), 32'b1101);
        #2;
        clear = 1'b0;
        #1;
        check("mid_rst_row", 32'(row0), 32'hF);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_kd", 32'(kd0), 32'd0);
        check("mid_rst_rdy", 32'(if0.req_ready), 32'd0);
        @(negedge clk);
        #1;
        clear = 1'b1;
        #1;
        check("mid_rel_rdy_before", 32'(if0.req_ready), 32'd0);
        @(negedge clk);
        check("mid_rel_rdy_after", 32'(if0.req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mid_dropped_busy%0d", k), 32'(busy0), 32'd0);
            check($sformatf("mid_dropped_row%0d", k), 32'(row0), 32'hF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
